// File: rtl/axi_burst_rd_slave.sv
// AXI4 read-channel responder for the instruction-fetch refill path.
// Serves one FIXED/INCR/WRAP burst at a time from a 1-cycle-latency 64-bit SRAM through a 2-entry output buffer.
module axi_burst_rd_slave #(
    parameter logic [31:0] MEM_BASE = 32'h8000_0000,
    parameter logic [31:0] MEM_SIZE = 32'h0800_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    input  logic [1:0]  arburst,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    output logic [63:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    output logic        rlast,
    input  logic        rready,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  burst_q, burst_d;
    logic [7:0]  len_q, len_d;
    logic [2:0]  size_q, size_d;
    logic        err_q, err_d;
    logic [7:0]  issued_q, issued_d;
    logic        inflight_q, inflight_d;
    logic        infl_err_q, infl_err_d;
    logic        infl_last_q, infl_last_d;
    logic [63:0] buf_data_q [0:1];
    logic [63:0] buf_data_d [0:1];
    logic [1:0]  buf_resp_q [0:1];
    logic [1:0]  buf_resp_d [0:1];
    logic        buf_last_q [0:1];
    logic        buf_last_d [0:1];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;

    logic        pop_s;
    logic        push_s;
    logic [2:0]  occ_s;
    logic        issue_s;

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst,
                                              input logic [7:0] len, input logic [2:0] size);
        logic [31:0] step;
        logic [31:0] mask;
        step = 32'd1 << size;
        mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
        case (burst)
            2'b00:   next_addr = addr;
            2'b01:   next_addr = addr + step;
            2'b10:   next_addr = (addr & ~mask) | ((addr + step) & mask);
            default: next_addr = addr;
        endcase
    endfunction

    function automatic logic ar_error(input logic [31:0] addr, input logic [1:0] burst,
                                      input logic [7:0] len, input logic [2:0] size);
        logic [32:0] limit;
        logic [12:0] bytes;
        logic        cross_4k;
        logic        wrap_len_ok;
        limit       = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};
        bytes       = ({5'd0, len} + 13'd1) << size[1:0];
        cross_4k    = ({1'b0, addr[11:0]} + bytes) > 13'd4096;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        ar_error    = (burst == 2'b11) || (size > 3'd3) || (addr < MEM_BASE) ||
                      ({1'b0, addr} >= limit) || ((burst == 2'b10) && !wrap_len_ok) ||
                      ((burst == 2'b01) && cross_4k);
    endfunction

    // Popping the head this cycle frees a slot, so back-to-back issue is possible under rready=1.
    assign pop_s    = (count_q != 2'd0) && rready;
    assign push_s   = inflight_q;
    assign occ_s    = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    assign issue_s  = (state_q == S_BURST) && (occ_s < 3'd2);

    assign arready  = (state_q == S_IDLE);
    assign mem_en   = issue_s && !err_q;
    assign mem_addr = {addr_q[31:3], 3'b000};
    assign rvalid   = (count_q != 2'd0);
    assign rdata    = rvalid ? buf_data_q[rd_ptr_q] : 64'd0;
    assign rresp    = rvalid ? buf_resp_q[rd_ptr_q] : 2'b00;
    assign rlast    = rvalid ? buf_last_q[rd_ptr_q] : 1'b0;

    // Next-state: burst sequencing, beat issue and output buffer bookkeeping.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        burst_d     = burst_q;
        len_d       = len_q;
        size_d      = size_q;
        err_d       = err_q;
        issued_d    = issued_q;
        inflight_d  = issue_s;
        infl_err_d  = err_q;
        infl_last_d = (issued_q == len_q);
        buf_data_d  = buf_data_q;
        buf_resp_d  = buf_resp_q;
        buf_last_d  = buf_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;

        case (state_q)
            S_IDLE: begin
                if (arvalid) begin
                    state_d  = S_BURST;
                    addr_d   = araddr;
                    burst_d  = arburst;
                    len_d    = arlen;
                    size_d   = arsize;
                    err_d    = ar_error(araddr, arburst, arlen, arsize);
                    issued_d = 8'd0;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_BURST: begin
                if (issue_s) begin
                    addr_d   = next_addr(addr_q, burst_q, len_q, size_q);
                    issued_d = issued_q + 8'd1;
                    if (issued_q == len_q) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_BURST;
                    end
                end else begin
                    state_d = S_BURST;
                end
            end
            S_DRAIN: begin
                if (pop_s && buf_last_q[rd_ptr_q]) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Error beats ride the same in-flight slot as SRAM reads but carry zero data.
        if (push_s) begin
            buf_data_d[wr_ptr_q] = infl_err_q ? 64'd0 : mem_rdata;
            buf_resp_d[wr_ptr_q] = infl_err_q ? 2'b10 : 2'b00;
            buf_last_d[wr_ptr_q] = infl_last_q;
            wr_ptr_d             = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        count_d = count_q + {1'b0, push_s} - {1'b0, pop_s};
    end

    // State register with synchronous active-low reset that also drops any in-flight read.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            addr_q        <= 32'd0;
            burst_q       <= 2'b00;
            len_q         <= 8'd0;
            size_q        <= 3'd0;
            err_q         <= 1'b0;
            issued_q      <= 8'd0;
            inflight_q    <= 1'b0;
            infl_err_q    <= 1'b0;
            infl_last_q   <= 1'b0;
            buf_data_q[0] <= 64'd0;
            buf_data_q[1] <= 64'd0;
            buf_resp_q[0] <= 2'b00;
            buf_resp_q[1] <= 2'b00;
            buf_last_q[0] <= 1'b0;
            buf_last_q[1] <= 1'b0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            burst_q       <= burst_d;
            len_q         <= len_d;
            size_q        <= size_d;
            err_q         <= err_d;
            issued_q      <= issued_d;
            inflight_q    <= inflight_d;
            infl_err_q    <= infl_err_d;
            infl_last_q   <= infl_last_d;
            buf_data_q    <= buf_data_d;
            buf_resp_q    <= buf_resp_d;
            buf_last_q    <= buf_last_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

endmodule
